// File: rtl/pong_timing_pkg.sv
// Shared timing types and constants for the pong tick scheduler: phase encoding,
// counter width, default divisors and the ball-period helper.
package pong_timing_pkg;

  localparam int unsigned CNT_W = 32;
  localparam int unsigned RED_W = CNT_W + 5;

  localparam int unsigned DEF_BALL_BASE_DIV  = 2000000;
  localparam int unsigned DEF_SPEED_STEP     = 250000;
  localparam int unsigned DEF_BALL_MIN_DIV   = 500000;
  localparam int unsigned DEF_HITS_PER_LEVEL = 4;
  localparam int unsigned DEF_MAX_LEVEL      = 6;
  localparam int unsigned DEF_PADDLE_DIV     = 1000000;
  localparam int unsigned DEF_SCAN_DIV       = 100000;
  localparam int unsigned DEF_SERVE_CYCLES   = 50000000;

  typedef enum logic [1:0] {
    PhIdle   = 2'd0,
    PhServe  = 2'd1,
    PhPlay   = 2'd2,
    PhPaused = 2'd3
  } phase_e;

  // max(base - lvl*step, min) without ever letting the subtraction wrap.
  function automatic logic [CNT_W-1:0] ball_period(input logic [CNT_W-1:0] base_div,
                                                   input logic [CNT_W-1:0] step,
                                                   input logic [CNT_W-1:0] min_div,
                                                   input logic [3:0]       lvl);
    logic [RED_W-1:0] red;
    red = RED_W'(lvl) * RED_W'(step);
    if (RED_W'(base_div) <= RED_W'(min_div) + red) begin
      return min_div;
    end
    return base_div - red[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/pong_tick_gen.sv
// Modulo counter with a runtime period and a registered one-cycle tick; the
// terminal test is >= so a period that shrinks mid-count fires on the next cycle.
module pong_tick_gen
  import pong_timing_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [CNT_W-1:0] period,
  output logic             tick
);

  logic [CNT_W-1:0] cnt_q;
  logic             tick_q;
  logic             terminal;

  assign terminal = cnt_q >= period - CNT_W'(1);
  assign tick     = tick_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else if (clr) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else if (en) begin
      if (terminal) begin
        cnt_q  <= '0;
        tick_q <= 1'b1;
      end else begin
        cnt_q  <= cnt_q + CNT_W'(1);
        tick_q <= 1'b0;
      end
    end else begin
      tick_q <= 1'b0;
    end
  end

endmodule

// File: rtl/pong_tick_scheduler.sv
// Game-phase FSM, serve delay and speed-level tracking driving three tick
// generators (ball, paddle, display scan) in the single clk domain.
module pong_tick_scheduler
  import pong_timing_pkg::*;
#(
  parameter int unsigned BALL_BASE_DIV  = DEF_BALL_BASE_DIV,
  parameter int unsigned SPEED_STEP     = DEF_SPEED_STEP,
  parameter int unsigned BALL_MIN_DIV   = DEF_BALL_MIN_DIV,
  parameter int unsigned HITS_PER_LEVEL = DEF_HITS_PER_LEVEL,
  parameter int unsigned MAX_LEVEL      = DEF_MAX_LEVEL,
  parameter int unsigned PADDLE_DIV     = DEF_PADDLE_DIV,
  parameter int unsigned SCAN_DIV       = DEF_SCAN_DIV,
  parameter int unsigned SERVE_CYCLES   = DEF_SERVE_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pause_toggle,
  input  logic       hit,
  input  logic       miss,
  output logic       ball_tick,
  output logic       paddle_tick,
  output logic       scan_tick,
  output logic [3:0] level,
  output logic [1:0] phase
);

  phase_e           phase_q, phase_d;
  logic [CNT_W-1:0] serve_cnt_q;
  logic [CNT_W-1:0] hit_cnt_q;
  logic [3:0]       level_q;
  logic             hit_ok;
  logic             ball_en, ball_clr;
  logic             paddle_en, paddle_clr;
  logic             run_now, run_next;
  logic [CNT_W-1:0] ball_div;

  always_comb begin
    phase_d = phase_q;
    unique case (phase_q)
      PhIdle:   if (start) phase_d = PhServe;
      PhServe:  if (serve_cnt_q >= CNT_W'(SERVE_CYCLES - 1)) phase_d = PhPlay;
      PhPlay: begin
        if (miss) begin
          phase_d = PhServe;
        end else if (pause_toggle) begin
          phase_d = PhPaused;
        end
      end
      PhPaused: if (pause_toggle) phase_d = PhPlay;
    endcase
  end

  assign hit_ok = (phase_q == PhPlay) && hit && !miss;

  // A counter only advances on an edge that both starts and ends in a running
  // phase, so no tick can land in a cycle where its counter is stopped.
  assign run_now    = (phase_q == PhServe) || (phase_q == PhPlay);
  assign run_next   = (phase_d == PhServe) || (phase_d == PhPlay);
  assign paddle_en  = run_now && run_next;
  assign paddle_clr = (phase_q == PhIdle);
  assign ball_en    = (phase_q == PhPlay) && (phase_d == PhPlay);
  assign ball_clr   = (phase_q == PhIdle) || (phase_q == PhServe) ||
                      ((phase_q == PhPlay) && (phase_d == PhServe));

  assign ball_div = ball_period(CNT_W'(BALL_BASE_DIV), CNT_W'(SPEED_STEP),
                                CNT_W'(BALL_MIN_DIV), level_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q     <= PhIdle;
      serve_cnt_q <= '0;
      hit_cnt_q   <= '0;
      level_q     <= '0;
    end else begin
      phase_q <= phase_d;
      if ((phase_q == PhServe) && (phase_d == PhServe)) begin
        serve_cnt_q <= serve_cnt_q + CNT_W'(1);
      end else begin
        serve_cnt_q <= '0;
      end
      if ((phase_q == PhPlay) && miss) begin
        hit_cnt_q <= '0;
        level_q   <= '0;
      end else if (hit_ok) begin
        if (hit_cnt_q >= CNT_W'(HITS_PER_LEVEL - 1)) begin
          hit_cnt_q <= '0;
          if (level_q < 4'(MAX_LEVEL)) begin
            level_q <= level_q + 4'd1;
          end
        end else begin
          hit_cnt_q <= hit_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  assign level = level_q;
  assign phase = phase_q;

  pong_tick_gen u_ball (
    .clk    (clk),
    .rst    (rst),
    .en     (ball_en),
    .clr    (ball_clr),
    .period (ball_div),
    .tick   (ball_tick)
  );

  pong_tick_gen u_paddle (
    .clk    (clk),
    .rst    (rst),
    .en     (paddle_en),
    .clr    (paddle_clr),
    .period (CNT_W'(PADDLE_DIV)),
    .tick   (paddle_tick)
  );

  pong_tick_gen u_scan (
    .clk    (clk),
    .rst    (rst),
    .en     (1'b1),
    .clr    (1'b0),
    .period (CNT_W'(SCAN_DIV)),
    .tick   (scan_tick)
  );

endmodule

// File: tb/tb_pong_tick_scheduler.sv
// Directed plus randomized bench for pong_tick_scheduler against a cycle-level
// reference model built from the game rules.
module tb_pong_tick_scheduler;
  import pong_timing_pkg::*;

  localparam int unsigned BASE  = 20;
  localparam int unsigned STEP  = 4;
  localparam int unsigned MINP  = 8;
  localparam int unsigned HPL   = 2;
  localparam int unsigned MAXL  = 3;
  localparam int unsigned PAD   = 5;
  localparam int unsigned SCAN  = 3;
  localparam int unsigned SERVE = 10;

  logic       clk, rst, start, pause_toggle, hit, miss;
  logic       ball_tick, paddle_tick, scan_tick;
  logic [3:0] level;
  logic [1:0] phase;

  pong_tick_scheduler #(
    .BALL_BASE_DIV  (BASE),
    .SPEED_STEP     (STEP),
    .BALL_MIN_DIV   (MINP),
    .HITS_PER_LEVEL (HPL),
    .MAX_LEVEL      (MAXL),
    .PADDLE_DIV     (PAD),
    .SCAN_DIV       (SCAN),
    .SERVE_CYCLES   (SERVE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .pause_toggle (pause_toggle),
    .hit          (hit),
    .miss         (miss),
    .ball_tick    (ball_tick),
    .paddle_tick  (paddle_tick),
    .scan_tick    (scan_tick),
    .level        (level),
    .phase        (phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1);
  end

  int n_cmp, n_fail;
  // Model state: phase 0..3, level, hits, serve delay, elapsed running edges.
  int m_phase, m_level, m_hits, m_serve, m_ball, m_pad, m_scan;
  int e_ball, e_pad, e_scan;

  task automatic model_reset();
    m_phase = 0; m_level = 0; m_hits = 0; m_serve = 0;
    m_ball = 0; m_pad = 0; m_scan = 0;
    e_ball = 0; e_pad = 0; e_scan = 0;
  endtask

  function automatic bit is_running(input int p);
    return (p == 1) || (p == 2);
  endfunction

  task automatic model_step(input bit st, input bit pt, input bit h, input bit m);
    int nphase;
    int period;
    nphase = m_phase;
    case (m_phase)
      0: if (st) nphase = 1;
      1: if (m_serve == int'(SERVE) - 1) nphase = 2;
      2: if (m) nphase = 1; else if (pt) nphase = 3;
      default: if (pt) nphase = 2;
    endcase
    m_scan++;
    e_scan = (m_scan % int'(SCAN) == 0) ? 1 : 0;
    period = int'(BASE) - m_level * int'(STEP);
    if (period < int'(MINP)) period = int'(MINP);
    e_ball = 0;
    if (m_phase == 2 && nphase == 2) begin
      m_ball++;
      if (m_ball >= period) begin e_ball = 1; m_ball = 0; end
    end else if (m_phase <= 1 || nphase == 1) begin
      m_ball = 0;
    end
    e_pad = 0;
    if (is_running(m_phase) && is_running(nphase)) begin
      m_pad++;
      if (m_pad >= int'(PAD)) begin e_pad = 1; m_pad = 0; end
    end else if (m_phase == 0) begin
      m_pad = 0;
    end
    m_serve = (m_phase == 1 && nphase == 1) ? m_serve + 1 : 0;
    if (m_phase == 2) begin
      if (m) begin
        m_level = 0; m_hits = 0;
      end else if (h) begin
        m_hits++;
        if (m_hits == int'(HPL)) begin
          m_hits = 0;
          if (m_level < int'(MAXL)) m_level++;
        end
      end
    end
    m_phase = nphase;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    check("ball_tick", 32'(ball_tick), e_ball);
    check("paddle_tick", 32'(paddle_tick), e_pad);
    check("scan_tick", 32'(scan_tick), e_scan);
    check("phase", 32'(phase), m_phase);
    check("level", 32'(level), m_level);
  endtask

  task automatic step(input bit st, input bit pt, input bit h, input bit m);
    start = st; pause_toggle = pt; hit = h; miss = m;
    @(posedge clk);
    model_step(st, pt, h, m);
    @(negedge clk);
    start = 1'b0; pause_toggle = 1'b0; hit = 1'b0; miss = 1'b0;
    check_outputs();
  endtask

  task automatic wait_ball(input string tag, input int bound, output int n);
    n = 0;
    do begin
      step(0, 0, 0, 0);
      n++;
    end while (!ball_tick && n < bound);
    check({tag, " reached"}, 32'(ball_tick), 1);
  endtask

  task automatic wait_phase(input string tag, input int target, input int bound, output int n);
    n = 0;
    do begin
      step(0, 0, 0, 0);
      n++;
    end while (int'(phase) != target && n < bound);
    check({tag, " reached"}, 32'(phase), target);
  endtask

  int n, nb, np, ns;

  initial begin
    n_cmp = 0; n_fail = 0;
    rst = 1'b1; start = 1'b0; pause_toggle = 1'b0; hit = 1'b0; miss = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset ball_tick", 32'(ball_tick), 0);
    check("reset paddle_tick", 32'(paddle_tick), 0);
    check("reset scan_tick", 32'(scan_tick), 0);
    check("reset phase", 32'(phase), 0);
    check("reset level", 32'(level), 0);
    rst = 1'b0;

    // 1: idle, only the scan tick runs
    nb = 0; np = 0; ns = 0;
    for (int i = 0; i < 200; i++) begin
      step(0, 0, 0, 0);
      nb += int'(ball_tick); np += int'(paddle_tick); ns += int'(scan_tick);
    end
    check("t1 ball ticks", nb, 0);
    check("t1 paddle ticks", np, 0);
    check("t1 scan ticks", ns, 66);

    // 2: serve then play
    step(1, 0, 0, 0);
    check("t2 serve entered", 32'(phase), 1);
    wait_phase("t2 play", 2, 40, n);
    check("t2 serve length", n, 10);
    wait_ball("t2 first ball", 60, n);
    check("t2 first ball delay", n, 20);
    wait_ball("t2 ball", 60, n);
    check("t2 ball spacing", n, 20);

    // 3: level progression and saturation
    step(0, 0, 1, 0); step(0, 0, 0, 0); step(0, 0, 1, 0);
    check("t3 level1", 32'(level), 1);
    wait_ball("t3 sync1", 60, n);
    wait_ball("t3 l1", 60, n);
    check("t3 spacing l1", n, 16);
    for (int i = 0; i < 6; i++) begin step(0, 0, 1, 0); step(0, 0, 0, 0); end
    check("t3 level sat", 32'(level), 3);
    wait_ball("t3 sync3", 60, n);
    wait_ball("t3 l3", 60, n);
    check("t3 spacing l3", n, 8);
    for (int i = 0; i < 4; i++) begin step(0, 0, 1, 0); step(0, 0, 0, 0); end
    check("t3 level held", 32'(level), 3);

    // 4: pause/resume at level 0
    step(0, 0, 0, 1);
    check("t4 level cleared", 32'(level), 0);
    wait_phase("t4 play", 2, 40, n);
    wait_ball("t4 sync", 60, n);
    repeat (7) step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    check("t4 paused", 32'(phase), 3);
    nb = 0; np = 0; ns = 0;
    for (int i = 0; i < 100; i++) begin
      step(0, 0, 0, 0);
      nb += int'(ball_tick); np += int'(paddle_tick); ns += int'(scan_tick);
    end
    check("t4 ball while paused", nb, 0);
    check("t4 paddle while paused", np, 0);
    check("t4 scan while paused", 32'(ns >= 33), 1);
    step(0, 1, 0, 0);
    check("t4 resumed", 32'(phase), 2);
    wait_ball("t4 resume", 60, n);
    check("t4 resume delay", n, 13);

    // 5: hit and miss together at level 2
    for (int i = 0; i < 4; i++) begin step(0, 0, 1, 0); step(0, 0, 0, 0); end
    check("t5 level2", 32'(level), 2);
    step(0, 0, 1, 1);
    check("t5 serve", 32'(phase), 1);
    check("t5 level0", 32'(level), 0);
    nb = 0;
    for (int i = 0; i < 10; i++) begin step(0, 0, 0, 0); nb += int'(ball_tick); end
    check("t5 no ball in serve", nb, 0);
    check("t5 back to play", 32'(phase), 2);
    step(0, 0, 1, 0);
    check("t5 hit count cleared", 32'(level), 0);
    step(0, 0, 1, 0);
    check("t5 level after two hits", 32'(level), 1);

    // Randomized play against the model
    for (int i = 0; i < 1500; i++) begin
      step(($urandom % 50) == 0, ($urandom % 40) == 0, ($urandom % 6) == 0,
           ($urandom % 80) == 0);
    end

    // 6: asynchronous reset mid-play
    if (int'(phase) == 3) step(0, 1, 0, 0);
    if (int'(phase) != 2) wait_phase("t6 play", 2, 40, n);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("t6 ball_tick", 32'(ball_tick), 0);
    check("t6 paddle_tick", 32'(paddle_tick), 0);
    check("t6 scan_tick", 32'(scan_tick), 0);
    check("t6 phase", 32'(phase), 0);
    check("t6 level", 32'(level), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (4) step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    check("t6 serve", 32'(phase), 1);
    wait_phase("t6 play", 2, 40, n);
    check("t6 serve length", n, 10);
    wait_ball("t6 first ball", 60, n);
    check("t6 first ball delay", n, 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pong_tick_scheduler.md
Name: pong_tick_scheduler

Overview:
Central timing controller for the pong game. It derives single-cycle enable ticks from the system clock for ball motion, paddle motion and display scan. Game logic stays in the clk domain with no derived clocks. A small game-phase FSM gates the ticks and raises ball speed with paddle hits. It sits between the top level and the ball, paddle and VGA/7-seg logic, replacing per-block clock dividers.

Parameters:
BALL_BASE_DIV, 2000000, clk cycles per ball step at level 0
SPEED_STEP, 250000, period reduction per speed level
BALL_MIN_DIV, 500000, floor on ball period (must be >= 2)
HITS_PER_LEVEL, 4, paddle hits needed to advance one level
MAX_LEVEL, 6, saturating level limit (must be <= 15)
PADDLE_DIV, 1000000, clk cycles per paddle step
SCAN_DIV, 100000, clk cycles per display scan tick
SERVE_CYCLES, 50000000, serve delay in clk cycles

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
start  input  1  single-cycle pulse, begin game from IDLE
pause_toggle  input  1  single-cycle pulse, PLAY<->PAUSED
hit  input  1  single-cycle pulse, ball hit a paddle
miss  input  1  single-cycle pulse, point scored
ball_tick  output  1  one-cycle enable for ball update
paddle_tick  output  1  one-cycle enable for paddle update
scan_tick  output  1  one-cycle enable for display multiplexing
level  output  4  current speed level
phase  output  2  FSM state, encoding from package

Behaviour:
- Reset, asynchronous: phase=IDLE, level=0, hit count=0. All tick outputs are 0. All counters are 0.
- Every tick is registered, high exactly one cycle per period, and never high while its counter is disabled.
- scan_tick runs in every phase. Period is SCAN_DIV. First pulse comes SCAN_DIV cycles after reset release.
- FSM states: IDLE, SERVE, PLAY, PAUSED.
- IDLE: ball and paddle counters are held at 0. start -> SERVE.
- SERVE: paddle counter runs. Ball counter is held at 0. Serve counter counts to SERVE_CYCLES-1, then -> PLAY on the next edge.
- PLAY: ball and paddle counters run. miss -> SERVE; this clears level, hit count and the serve counter. pause_toggle -> PAUSED.
- PAUSED: ball and paddle counters freeze, keeping their values. pause_toggle -> PLAY, and counting resumes where it stopped.
- start outside IDLE is ignored. hit outside PLAY is ignored.
- Simultaneous events in PLAY: miss has priority over pause_toggle and hit. A hit in the same cycle as a miss is discarded.
- Ball period = max(BALL_BASE_DIV - level*SPEED_STEP, BALL_MIN_DIV). Compute it in 32 bits, with no underflow: clamp before subtracting.
- Ball counter terminal condition is count >= period-1. This gives a pulse and clears the counter. A period that shrinks mid-count therefore fires on the next cycle rather than wrapping.
- Level update: each hit in PLAY increments the hit count. When the count reaches HITS_PER_LEVEL it clears, and level increments while level < MAX_LEVEL. At MAX_LEVEL, level holds and the count keeps cycling.
- A new level takes effect on the cycle after the hit. Latency: hit at edge N gives level updated at N+1, and the new period applies from N+1.
- Paddle and scan counters wrap at DIV-1 with a pulse on the wrap cycle.
- A reset mid-operation returns to IDLE immediately, with ticks at 0 in the same instant.

Decomposition:
- Package pong_timing_pkg holds:
  - the phase encoding: IDLE=0, SERVE=1, PLAY=2, PAUSED=3
  - the counter width constant CNT_W=32
  - the default divisor constants
- Sub-module pong_tick_gen: a CNT_W modulo counter with inputs en, clr and a runtime period, and a registered one-cycle tick output using the >= terminal rule. Instantiate it three times: ball, paddle, scan.
- The FSM, serve counter and level logic live in the top module.

Test Plan:
All scenarios use BALL_BASE_DIV=20, SPEED_STEP=4, BALL_MIN_DIV=8, HITS_PER_LEVEL=2, MAX_LEVEL=3, PADDLE_DIV=5, SCAN_DIV=3, SERVE_CYCLES=10.
1. Reset release with no inputs -> phase=IDLE, scan_tick every 3 cycles, ball_tick and paddle_tick stay 0 for 200 cycles.
2. start pulse -> phase=SERVE next cycle, paddle_tick every 5 cycles, no ball_tick, phase=PLAY after 10 cycles, ball_tick spacing 20.
3. In PLAY, 2 hits -> level=1, spacing 16; 6 more hits -> level saturates at 3, spacing max(20-12, 8)=8; further hits leave level at 3.
4. pause_toggle 7 cycles after a ball_tick, wait 100, pause_toggle again -> no ball/paddle ticks while PAUSED, scan continues, next ball_tick 13 cycles after resume at level 0.
5. hit and miss in the same cycle at level 2 -> phase=SERVE, level=0, hit count 0, ball_tick absent for 10 cycles.
6. rst asserted mid-PLAY between clock edges -> outputs 0 and phase=IDLE before the next edge; start again gives a clean SERVE sequence.
